// File: rtl/bpred_train_queue.sv
// PHT training queue: turns resolved branch outcomes into saturating-counter
// updates, buffers them in a small FIFO drained by the PHT write port, and
// forwards in-flight states to the fetch-side lookup.

// Per-entry index comparator. The lookup and resolve paths each need their own match.
module bpred_train_entry #(
    parameter int k = 10
) (
    input  logic         entValid,
    input  logic [k-1:0] entIndex,
    input  logic [k-1:0] lookupIndex,
    input  logic [k-1:0] resolveIndex,
    output logic         lookupMatch,
    output logic         resolveMatch
);
    assign lookupMatch  = entValid && (entIndex == lookupIndex);
    assign resolveMatch = entValid && (entIndex == resolveIndex);
endmodule

module bpred_train_queue #(
    parameter int k     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         FlushQ,
    input  logic         ResolveValid,
    output logic         ResolveReady,
    input  logic [k-1:0] ResolveIndex,
    input  logic         ResolveTaken,
    input  logic [1:0]   ResolveOldState,
    output logic         WrValid,
    input  logic         WrReady,
    output logic [k-1:0] WrIndex,
    output logic [1:0]   WrState,
    input  logic [k-1:0] LookupIndex,
    output logic         LookupHit,
    output logic [1:0]   LookupState,
    output logic [15:0]  DropCount
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][k-1:0] entIndex;
    logic [DEPTH-1:0][1:0]   entState;
    logic [PW-1:0]           headPtr, tailPtr;
    logic [PW:0]             count;
    logic [15:0]             dropCnt;

    logic [DEPTH-1:0] entValid;
    logic [DEPTH-1:0] lookupMatch, resolveMatch;
    logic [PW-1:0]    slotV, slotP;
    logic             resolveHit;
    logic [1:0]       resolveHitState, baseState, newState;
    logic             push, pop, drop;

    // Mark the slots holding pending entries, walking from the head.
    always_comb begin
        entValid = '0;
        slotV    = '0;
        for (int a = 0; a < DEPTH; a++) begin
            slotV = headPtr + PW'(a);
            if ((PW+1)'(a) < count)
                entValid[slotV] = 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : gEnt
            bpred_train_entry #(.k(k)) uEnt (
                .entValid     (entValid[g]),
                .entIndex     (entIndex[g]),
                .lookupIndex  (LookupIndex),
                .resolveIndex (ResolveIndex),
                .lookupMatch  (lookupMatch[g]),
                .resolveMatch (resolveMatch[g])
            );
        end
    endgenerate

    // Oldest-to-youngest walk so the youngest match wins for both lookup and resolve.
    always_comb begin
        LookupHit       = 1'b0;
        LookupState     = 2'b00;
        resolveHit      = 1'b0;
        resolveHitState = 2'b00;
        slotP           = '0;
        for (int a = 0; a < DEPTH; a++) begin
            slotP = headPtr + PW'(a);
            if (lookupMatch[slotP]) begin
                LookupHit   = 1'b1;
                LookupState = entState[slotP];
            end
            if (resolveMatch[slotP]) begin
                resolveHit      = 1'b1;
                resolveHitState = entState[slotP];
            end
        end
    end

    // Saturating 2-bit counter update; chains onto in-flight training for the same index.
    always_comb begin
        baseState = resolveHit ? resolveHitState : ResolveOldState;
        newState  = baseState;
        if (ResolveTaken) begin
            if (baseState != 2'b11) newState = baseState + 2'b01;
        end else begin
            if (baseState != 2'b00) newState = baseState - 2'b01;
        end
    end

    assign ResolveReady = (count != (PW+1)'(DEPTH));
    assign WrValid      = (count != '0);
    assign WrIndex      = WrValid ? entIndex[headPtr] : '0;
    assign WrState      = WrValid ? entState[headPtr] : 2'b00;
    assign DropCount    = dropCnt;

    // A flush overrides any push/pop in the same cycle, including drop accounting.
    assign push = ResolveValid && ResolveReady && !FlushQ;
    assign pop  = WrValid && WrReady && !FlushQ;
    assign drop = ResolveValid && !ResolveReady && !FlushQ;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            count    <= '0;
            entIndex <= '0;
            entState <= '0;
        end else if (FlushQ) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                entIndex[tailPtr] <= ResolveIndex;
                entState[tailPtr] <= newState;
                tailPtr           <= tailPtr + 1'b1;
            end
            if (pop)
                headPtr <= headPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating count of outcomes lost because the queue was full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dropCnt <= '0;
        else if (drop && dropCnt != 16'hFFFF)
            dropCnt <= dropCnt + 16'd1;
    end
endmodule

// File: tb/tb_bpred_train_queue.sv
// Directed bench for bpred_train_queue: chaining, fill/drop, drain, flush,
// wrap-around and asynchronous reset.
module tb_bpred_train_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        FlushQ = 1'b0;
    logic        ResolveValid = 1'b0;
    logic        ResolveReady;
    logic [9:0]  ResolveIndex = '0;
    logic        ResolveTaken = 1'b0;
    logic [1:0]  ResolveOldState = 2'b00;
    logic        WrValid;
    logic        WrReady = 1'b0;
    logic [9:0]  WrIndex;
    logic [1:0]  WrState;
    logic [9:0]  LookupIndex = '0;
    logic        LookupHit;
    logic [1:0]  LookupState;
    logic [15:0] DropCount;

    int errors = 0;
    int checks = 0;

    bpred_train_queue #(.k(10), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .FlushQ(FlushQ),
        .ResolveValid(ResolveValid), .ResolveReady(ResolveReady),
        .ResolveIndex(ResolveIndex), .ResolveTaken(ResolveTaken),
        .ResolveOldState(ResolveOldState),
        .WrValid(WrValid), .WrReady(WrReady), .WrIndex(WrIndex), .WrState(WrState),
        .LookupIndex(LookupIndex), .LookupHit(LookupHit), .LookupState(LookupState),
        .DropCount(DropCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] idx, input logic tk, input logic [1:0] old);
        ResolveValid = 1'b1; ResolveIndex = idx; ResolveTaken = tk; ResolveOldState = old;
        tick();
        ResolveValid = 1'b0;
    endtask

    task automatic flush();
        FlushQ = 1'b1;
        tick();
        FlushQ = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (WrValid !== 1'b0) begin errors++; $display("FAIL rst_wrvalid got=%0h exp=0", WrValid); end
        checks++; if (ResolveReady !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0h exp=1", ResolveReady); end
        checks++; if (LookupHit !== 1'b0) begin errors++; $display("FAIL rst_hit got=%0h exp=0", LookupHit); end
        checks++; if (DropCount !== 16'd0) begin errors++; $display("FAIL rst_drop got=%0h exp=0", DropCount); end
        checks++; if (WrIndex !== 10'd0 || WrState !== 2'b00 || LookupState !== 2'b00) begin errors++; $display("FAIL rst_zero idx=%0h st=%0h lst=%0h exp=0", WrIndex, WrState, LookupState); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        WrReady = 1'b0;
        push(10'h055, 1'b1, 2'b01);
        LookupIndex = 10'h055;
        #1;
        checks++; if (WrValid !== 1'b1) begin errors++; $display("FAIL basic_wrvalid got=%0h exp=1", WrValid); end
        checks++; if (WrIndex !== 10'h055) begin errors++; $display("FAIL basic_wrindex got=%0h exp=055", WrIndex); end
        checks++; if (WrState !== 2'b10) begin errors++; $display("FAIL basic_wrstate got=%0h exp=2", WrState); end
        checks++; if (LookupHit !== 1'b1 || LookupState !== 2'b10) begin errors++; $display("FAIL basic_lookup hit=%0h st=%0h exp=1/2", LookupHit, LookupState); end
        LookupIndex = 10'h056;
        #1;
        checks++; if (LookupHit !== 1'b0 || LookupState !== 2'b00) begin errors++; $display("FAIL basic_miss hit=%0h st=%0h exp=0/0", LookupHit, LookupState); end
        flush();
    endtask

    task automatic test_chain();
        WrReady = 1'b0;
        push(10'h010, 1'b1, 2'b10);
        push(10'h010, 1'b1, 2'b10);
        push(10'h010, 1'b0, 2'b11);
        LookupIndex = 10'h010;
        #1;
        checks++; if (LookupHit !== 1'b1 || LookupState !== 2'b10) begin errors++; $display("FAIL chain_lookup hit=%0h st=%0h exp=1/2", LookupHit, LookupState); end
        WrReady = 1'b1;
        #1;
        checks++; if (WrState !== 2'b11) begin errors++; $display("FAIL chain_e0 got=%0h exp=3", WrState); end
        tick();
        checks++; if (WrState !== 2'b11) begin errors++; $display("FAIL chain_e1 got=%0h exp=3", WrState); end
        tick();
        checks++; if (WrState !== 2'b10) begin errors++; $display("FAIL chain_e2 got=%0h exp=2", WrState); end
        tick();
        checks++; if (WrValid !== 1'b0) begin errors++; $display("FAIL chain_empty got=%0h exp=0", WrValid); end
        WrReady = 1'b0;
    endtask

    task automatic test_fill();
        WrReady = 1'b0;
        for (int i = 1; i <= 4; i++) push(10'(i), 1'b1, 2'b00);
        checks++; if (ResolveReady !== 1'b0) begin errors++; $display("FAIL fill_full got=%0h exp=0", ResolveReady); end
        push(10'h005, 1'b1, 2'b00);
        LookupIndex = 10'h005;
        #1;
        checks++; if (DropCount !== 16'd1) begin errors++; $display("FAIL fill_drop1 got=%0d exp=1", DropCount); end
        checks++; if (ResolveReady !== 1'b0 || WrIndex !== 10'h001) begin errors++; $display("FAIL fill_hold ready=%0h idx=%0h exp=0/001", ResolveReady, WrIndex); end
        checks++; if (LookupHit !== 1'b0) begin errors++; $display("FAIL fill_nostore got=%0h exp=0", LookupHit); end
        WrReady = 1'b1;
        push(10'h006, 1'b1, 2'b00);
        WrReady = 1'b0;
        checks++; if (DropCount !== 16'd2) begin errors++; $display("FAIL fill_drop2 got=%0d exp=2", DropCount); end
        checks++; if (ResolveReady !== 1'b1 || WrIndex !== 10'h002) begin errors++; $display("FAIL fill_pop ready=%0h idx=%0h exp=1/002", ResolveReady, WrIndex); end
        flush();
    endtask

    task automatic test_drain();
        WrReady = 1'b0;
        for (int i = 1; i <= 4; i++) push(10'(i), 1'b1, 2'b00);
        WrReady = 1'b1;
        #1;
        checks++; if (WrIndex !== 10'h001 || ResolveReady !== 1'b0) begin errors++; $display("FAIL drain_0 idx=%0h ready=%0h exp=001/0", WrIndex, ResolveReady); end
        tick();
        checks++; if (WrIndex !== 10'h002 || ResolveReady !== 1'b1) begin errors++; $display("FAIL drain_1 idx=%0h ready=%0h exp=002/1", WrIndex, ResolveReady); end
        tick();
        checks++; if (WrIndex !== 10'h003) begin errors++; $display("FAIL drain_2 got=%0h exp=003", WrIndex); end
        tick();
        checks++; if (WrIndex !== 10'h004 || WrState !== 2'b01) begin errors++; $display("FAIL drain_3 idx=%0h st=%0h exp=004/1", WrIndex, WrState); end
        tick();
        checks++; if (WrValid !== 1'b0 || WrIndex !== 10'h000) begin errors++; $display("FAIL drain_empty v=%0h idx=%0h exp=0/000", WrValid, WrIndex); end
        WrReady = 1'b0;
    endtask

    task automatic test_flush();
        WrReady = 1'b0;
        push(10'h100, 1'b1, 2'b00);
        push(10'h101, 1'b1, 2'b00);
        push(10'h102, 1'b1, 2'b00);
        LookupIndex = 10'h101;
        #1;
        checks++; if (LookupHit !== 1'b1 || LookupState !== 2'b01) begin errors++; $display("FAIL flush_pre hit=%0h st=%0h exp=1/1", LookupHit, LookupState); end
        FlushQ = 1'b1; WrReady = 1'b1;
        ResolveValid = 1'b1; ResolveIndex = 10'h103; ResolveTaken = 1'b1; ResolveOldState = 2'b00;
        tick();
        FlushQ = 1'b0; WrReady = 1'b0; ResolveValid = 1'b0;
        LookupIndex = 10'h100;
        #1;
        checks++; if (WrValid !== 1'b0 || ResolveReady !== 1'b1) begin errors++; $display("FAIL flush_empty v=%0h ready=%0h exp=0/1", WrValid, ResolveReady); end
        checks++; if (LookupHit !== 1'b0) begin errors++; $display("FAIL flush_hit100 got=%0h exp=0", LookupHit); end
        LookupIndex = 10'h103;
        #1;
        checks++; if (LookupHit !== 1'b0) begin errors++; $display("FAIL flush_hit103 got=%0h exp=0", LookupHit); end
        checks++; if (DropCount !== 16'd2) begin errors++; $display("FAIL flush_drop got=%0d exp=2", DropCount); end
    endtask

    task automatic test_wrap();
        WrReady = 1'b0;
        push(10'h200, 1'b1, 2'b01);
        push(10'h201, 1'b1, 2'b01);
        WrReady = 1'b1;
        for (int i = 2; i < 8; i++) begin
            ResolveValid = 1'b1; ResolveIndex = 10'h200 + 10'(i); ResolveTaken = 1'b1; ResolveOldState = 2'b01;
            #1;
            checks++; if (WrIndex !== 10'h200 + 10'(i - 2) || WrState !== 2'b10) begin errors++; $display("FAIL wrap_%0d idx=%0h st=%0h exp=%0h/2", i, WrIndex, WrState, 10'h200 + 10'(i - 2)); end
            tick();
        end
        ResolveValid = 1'b0;
        #1;
        checks++; if (WrIndex !== 10'h206) begin errors++; $display("FAIL wrap_tail0 got=%0h exp=206", WrIndex); end
        tick();
        checks++; if (WrIndex !== 10'h207) begin errors++; $display("FAIL wrap_tail1 got=%0h exp=207", WrIndex); end
        tick();
        checks++; if (WrValid !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%0h exp=0", WrValid); end
        WrReady = 1'b0;
    endtask

    task automatic test_async_reset();
        WrReady = 1'b0;
        push(10'h301, 1'b1, 2'b00);
        push(10'h302, 1'b1, 2'b00);
        push(10'h303, 1'b1, 2'b00);
        WrReady = 1'b1;
        tick();
        LookupIndex = 10'h302;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (WrValid !== 1'b0 || ResolveReady !== 1'b1) begin errors++; $display("FAIL arst_state v=%0h ready=%0h exp=0/1", WrValid, ResolveReady); end
        checks++; if (DropCount !== 16'd0) begin errors++; $display("FAIL arst_drop got=%0d exp=0", DropCount); end
        checks++; if (LookupHit !== 1'b0) begin errors++; $display("FAIL arst_hit got=%0h exp=0", LookupHit); end
        #1;
        reset = 1'b0;
        WrReady = 1'b0;
        push(10'h3AA, 1'b0, 2'b10);
        checks++; if (WrValid !== 1'b1 || WrIndex !== 10'h3AA || WrState !== 2'b01) begin errors++; $display("FAIL arst_push v=%0h idx=%0h st=%0h exp=1/3aa/1", WrValid, WrIndex, WrState); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_fill();
        test_drain();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
